// File: rtl/playback_reader_if.sv
// rtl/playback_reader_if.sv - control, memory and serializer signals of the playback reader
interface playback_reader_if #(
    parameter int ADDR_W = 17
);
    logic              start_i;
    logic              stop_i;
    logic [ADDR_W-1:0] last_addr_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic [15:0]       mem_data_i;
    logic              ser_done_i;
    logic              ser_enable_o;
    logic [15:0]       ser_data_o;
    logic              busy_o;
    logic              finished_o;

    // Reader side: consumes control, read data and done; drives memory and serializer.
    modport master (
        input  start_i, stop_i, last_addr_i, mem_data_i, ser_done_i,
        output mem_addr_o, mem_rd_o, ser_enable_o, ser_data_o, busy_o, finished_o
    );

    // Environment side: controller, memory and serializer.
    modport slave (
        output start_i, stop_i, last_addr_i, mem_data_i, ser_done_i,
        input  mem_addr_o, mem_rd_o, ser_enable_o, ser_data_o, busy_o, finished_o
    );
endinterface

// File: rtl/playback_reader.sv
// rtl/playback_reader.sv - walks sample memory and feeds words to the PDM serializer
module playback_reader #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input logic               clock_i,
    input logic               reset_i,
    playback_reader_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRIME    = 3'd1;
    localparam logic [2:0] S_PREFETCH = 3'd2;
    localparam logic [2:0] S_PLAY     = 3'd3;
    localparam logic [2:0] S_LAST     = 3'd4;

    // Counter value on the cycle the read data is valid; the count starts at 0
    // in the cycle the read strobe is high.
    localparam logic [1:0] LAT = 2'(RD_LAT);

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_q;
    logic [1:0]        cnt_q;
    logic [15:0]       stage_q;
    logic [15:0]       data_q;
    logic              rd_q;
    logic              en_q;
    logic              fin_q;
    logic              data_valid;
    logic              at_last;

    assign data_valid = (cnt_q == LAT);
    assign at_last    = (addr_q == last_q);

    // Playback sequencer: prime the first word, then prefetch one word ahead of the serializer.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            rd_q  <= 1'b0;
            fin_q <= 1'b0;
            if (state_q != S_IDLE && bus.stop_i) begin
                // Abort: anything still in flight from memory is simply never captured.
                state_q <= S_IDLE;
                en_q    <= 1'b0;
                data_q  <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_i && !bus.stop_i) begin
                            last_q  <= bus.last_addr_i;
                            addr_q  <= '0;
                            rd_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_PRIME;
                        end
                    end
                    S_PRIME: begin
                        if (data_valid) begin
                            data_q <= bus.mem_data_i;
                            en_q   <= 1'b1;
                            if (at_last) begin
                                state_q <= S_LAST;
                            end else begin
                                addr_q  <= addr_q + 1'b1;
                                rd_q    <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= S_PREFETCH;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_PREFETCH: begin
                        if (data_valid) begin
                            stage_q <= bus.mem_data_i;
                            state_q <= S_PLAY;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (bus.ser_done_i) begin
                            data_q <= stage_q;
                            // Compare before incrementing so the top address never wraps.
                            if (at_last) begin
                                state_q <= S_LAST;
                            end else begin
                                addr_q  <= addr_q + 1'b1;
                                rd_q    <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= S_PREFETCH;
                            end
                        end
                    end
                    S_LAST: begin
                        if (bus.ser_done_i) begin
                            en_q    <= 1'b0;
                            data_q  <= '0;
                            fin_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // The serializer's 17-cycle word period always outlasts the prefetch; done here means a broken serializer.
    assert property (@(posedge clock_i) disable iff (reset_i)
        !(state_q == S_PREFETCH && bus.ser_done_i));

    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_rd_o     = rd_q;
    assign bus.ser_enable_o = en_q;
    assign bus.ser_data_o   = data_q;
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.finished_o   = fin_q;
endmodule

// File: tb/tb_playback_reader.sv
// tb/tb_playback_reader.sv - directed bench for playback_reader at read latency 1 and 3
module tb_playback_reader;
    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start_v = 1'b0;
    logic        stop_v  = 1'b0;
    logic        done_v  = 1'b0;
    logic [16:0] last_v  = '0;
    int          checks  = 0;
    int          errors  = 0;
    logic [15:0] mem [16];

    playback_reader_if #(.ADDR_W(17)) b1 ();
    playback_reader_if #(.ADDR_W(17)) b3 ();

    assign b1.start_i     = start_v;
    assign b1.stop_i      = stop_v;
    assign b1.ser_done_i  = done_v;
    assign b1.last_addr_i = last_v;
    assign b3.start_i     = start_v;
    assign b3.stop_i      = stop_v;
    assign b3.ser_done_i  = done_v;
    assign b3.last_addr_i = last_v;

    playback_reader #(.ADDR_W(17), .RD_LAT(1)) u1 (.clock_i(clk), .reset_i(rst), .bus(b1));
    playback_reader #(.ADDR_W(17), .RD_LAT(3)) u3 (.clock_i(clk), .reset_i(rst), .bus(b3));

    always #5 clk = ~clk;

    // Memory models: data valid exactly RD_LAT cycles after the strobe cycle, DEAD otherwise.
    logic [15:0] d1 = '0;
    logic        v1 = 1'b0;
    logic [15:0] d3 [3];
    logic [2:0]  v3 = '0;
    always @(posedge clk) begin
        v1    <= b1.mem_rd_o;
        d1    <= mem[b1.mem_addr_o[3:0]];
        v3    <= {v3[1:0], b3.mem_rd_o};
        d3[0] <= mem[b3.mem_addr_o[3:0]];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign b1.mem_data_i = v1    ? d1    : 16'hDEAD;
    assign b3.mem_data_i = v3[2] ? d3[2] : 16'hDEAD;

    int rd1 = 0, rd3 = 0, fin1 = 0, fin3 = 0;
    always @(posedge clk) begin
        if (b1.mem_rd_o)   rd1  <= rd1 + 1;
        if (b3.mem_rd_o)   rd3  <= rd3 + 1;
        if (b1.finished_o) fin1 <= fin1 + 1;
        if (b3.finished_o) fin3 <= fin3 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_en1"}, 32'(b1.ser_enable_o), 32'd0);
        chk({tag, "_dat1"}, 32'(b1.ser_data_o), 32'd0);
        chk({tag, "_busy1"}, 32'(b1.busy_o), 32'd0);
        chk({tag, "_rd1"}, 32'(b1.mem_rd_o), 32'd0);
        chk({tag, "_en3"}, 32'(b3.ser_enable_o), 32'd0);
        chk({tag, "_dat3"}, 32'(b3.ser_data_o), 32'd0);
        chk({tag, "_busy3"}, 32'(b3.busy_o), 32'd0);
        chk({tag, "_rd3"}, 32'(b3.mem_rd_o), 32'd0);
    endtask

    // Start pulse in cycle s; returns in cycle s+5 with both readers presenting word w0.
    task automatic start_play(input logic [16:0] last, input logic [15:0] w0);
        start_v = 1'b1;
        last_v  = last;
        tick(1);
        start_v = 1'b0;
        chk("s1_rd1", 32'(b1.mem_rd_o), 32'd1);
        chk("s1_rd3", 32'(b3.mem_rd_o), 32'd1);
        chk("s1_addr1", 32'(b1.mem_addr_o), 32'd0);
        chk("s1_busy3", 32'(b3.busy_o), 32'd1);
        tick(1);
        chk("s2_en1", 32'(b1.ser_enable_o), 32'd0);
        tick(1);
        chk("s3_en1", 32'(b1.ser_enable_o), 32'd1);
        chk("s3_dat1", 32'(b1.ser_data_o), 32'(w0));
        chk("s3_en3", 32'(b3.ser_enable_o), 32'd0);
        tick(1);
        chk("s4_en3", 32'(b3.ser_enable_o), 32'd0);
        tick(1);
        chk("s5_en3", 32'(b3.ser_enable_o), 32'd1);
        chk("s5_dat3", 32'(b3.ser_data_o), 32'(w0));
    endtask

    // Holds the current word for n cycles, pulses done, checks the following cycle.
    task automatic serve(input logic [15:0] cur, input logic [15:0] nxt, input bit last, input int n);
        tick(n);
        chk("hold1", 32'(b1.ser_data_o), 32'(cur));
        chk("hold3", 32'(b3.ser_data_o), 32'(cur));
        done_v = 1'b1;
        tick(1);
        done_v = 1'b0;
        if (!last) begin
            chk("next1", 32'(b1.ser_data_o), 32'(nxt));
            chk("next3", 32'(b3.ser_data_o), 32'(nxt));
            chk("nofin1", 32'(b1.finished_o), 32'd0);
        end else begin
            chk("fin1", 32'(b1.finished_o), 32'd1);
            chk("fin3", 32'(b3.finished_o), 32'd1);
            chk_idle("end");
        end
    endtask

    int base_rd1, base_rd3, base_fin1, base_fin3;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0BAD;
        mem[0] = 16'hA5A5; mem[1] = 16'h1234; mem[2] = 16'hFFFF;

        // Reset state
        tick(2);
        chk_idle("rst");
        chk("rst_fin1", 32'(b1.finished_o), 32'd0);
        chk("rst_addr3", 32'(b3.mem_addr_o), 32'd0);
        #3 rst = 1'b0;
        tick(1);

        // Corner: start with stop in IDLE, done in IDLE
        start_v = 1'b1; stop_v = 1'b1;
        tick(1);
        start_v = 1'b0; stop_v = 1'b0;
        chk_idle("startstop");
        done_v = 1'b1;
        tick(1);
        done_v = 1'b0;
        tick(1);
        chk_idle("done_idle");
        chk("done_idle_fin1", 32'(b1.finished_o), 32'd0);

        // Nominal three words, with a start and last_addr change mid-playback
        base_rd1 = rd1; base_rd3 = rd3; base_fin1 = fin1; base_fin3 = fin3;
        start_play(17'd2, 16'hA5A5);
        start_v = 1'b1; last_v = 17'd0;
        tick(1);
        start_v = 1'b0;
        serve(16'hA5A5, 16'h1234, 1'b0, 11);
        serve(16'h1234, 16'hFFFF, 1'b0, 16);
        serve(16'hFFFF, 16'h0000, 1'b1, 16);
        tick(3);
        chk("nom_fin1_once", 32'(b1.finished_o), 32'd0);
        chk("nom_rds1", 32'(rd1 - base_rd1), 32'd3);
        chk("nom_rds3", 32'(rd3 - base_rd3), 32'd3);
        chk("nom_fins1", 32'(fin1 - base_fin1), 32'd1);
        chk("nom_fins3", 32'(fin3 - base_fin3), 32'd1);

        // Single word
        mem[0] = 16'h8001;
        base_rd1 = rd1; base_rd3 = rd3;
        start_play(17'd0, 16'h8001);
        serve(16'h8001, 16'h0000, 1'b1, 12);
        tick(2);
        chk("one_rds1", 32'(rd1 - base_rd1), 32'd1);
        chk("one_rds3", 32'(rd3 - base_rd3), 32'd1);

        // Stop mid-word, then replay from address 0
        for (int i = 0; i < 11; i++) mem[i] = 16'h3000 + 16'(i);
        base_fin1 = fin1; base_fin3 = fin3;
        start_play(17'd10, 16'h3000);
        serve(16'h3000, 16'h3001, 1'b0, 12);
        serve(16'h3001, 16'h3002, 1'b0, 16);
        tick(4);
        stop_v = 1'b1;
        tick(1);
        stop_v = 1'b0;
        chk_idle("stop");
        tick(3);
        chk("stop_nofin1", 32'(fin1 - base_fin1), 32'd0);
        chk("stop_nofin3", 32'(fin3 - base_fin3), 32'd0);
        start_play(17'd10, 16'h3000);
        stop_v = 1'b1;
        tick(1);
        stop_v = 1'b0;
        chk_idle("stop2");

        // Asynchronous reset while the latency-1 reader is prefetching
        tick(2);
        start_v = 1'b1; last_v = 17'd10;
        tick(1);
        start_v = 1'b0;
        tick(2);
        #3 rst = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_addr1", 32'(b1.mem_addr_o), 32'd0);
        start_v = 1'b1;
        tick(2);
        start_v = 1'b0;
        chk("arst_start_busy1", 32'(b1.busy_o), 32'd0);
        chk("arst_start_busy3", 32'(b3.busy_o), 32'd0);
        #3 rst = 1'b0;
        tick(1);

        // Eight-word sweep after reset release
        for (int i = 0; i < 8; i++) mem[i] = 16'h0F0F ^ (16'(i) * 16'h1111);
        base_rd1 = rd1; base_rd3 = rd3; base_fin1 = fin1; base_fin3 = fin3;
        start_play(17'd7, mem[0]);
        for (int i = 0; i < 8; i++)
            serve(mem[i], mem[i + 1], i == 7, (i == 0) ? 12 : 16);
        tick(3);
        chk("sweep_rds1", 32'(rd1 - base_rd1), 32'd8);
        chk("sweep_rds3", 32'(rd3 - base_rd3), 32'd8);
        chk("sweep_fins3", 32'(fin3 - base_fin3), 32'd1);
        chk("sweep_fins1", 32'(fin1 - base_fin1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
